muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with HI/LO result registers, extending the single-cycle ALU with MULT, MULTU, DIV and DIVU.
- Sits beside the ALU in the execute stage.
- Handshake is start/busy/done; the controller stalls on busy.
- Radix-2: one result bit per cycle; operand width is parametrised.

Parameters:
WIDTH, 32, operand width and HI/LO width in bits (even, >= 4)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  request a new operation; sampled only in IDLE
op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
a  in  WIDTH  operand rs (multiplicand / dividend)
b  in  WIDTH  operand rt (multiplier / divisor)
hi_we  in  1  MTHI: write wd into hi; honoured only when busy=0
lo_we  in  1  MTLO: write wd into lo; honoured only when busy=0
wd  in  WIDTH  write data for hi_we/lo_we
busy  out  1  operation in progress
done  out  1  one-cycle pulse: hi/lo just updated by a completed op
div_by_zero  out  1  valid with done; 1 if the divide had b=0
hi  out  WIDTH  HI register (product upper half / remainder)
lo  out  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset values:
  - state IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0.
  - Counter and internal operand registers are cleared.
  - Reset mid-operation aborts; no partial result reaches hi/lo.
- States: IDLE, RUN, FIX. All outputs are registered.
- IDLE, start=1 at edge N:
  - Capture op.
  - Capture |a| and |b| for signed ops, raw values for unsigned ops.
  - Record result signs:
    - product sign = a[W-1]^b[W-1];
    - quotient sign = a[W-1]^b[W-1];
    - remainder sign = a[W-1].
  - Counter loads WIDTH; state -> RUN; busy=1 after edge N.
- RUN:
  - One iteration per edge, counter decrements; state -> FIX after the iteration at edge N+WIDTH.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; quotient bit 1 when partial remainder >= divisor.
  - All intermediate arithmetic is WIDTH+1 bits wide so no carry is lost.
- FIX at edge N+WIDTH+1:
  - Apply two's-complement sign correction.
  - Write hi/lo: hi=product[2W-1:W], lo=product[W-1:0]; or hi=remainder, lo=quotient.
  - done=1, busy=0, state -> IDLE.
  - Total busy cycles = WIDTH+1 (33 at default).
- Divide by zero (op[1]=1, b=0 at start):
  - No RUN.
  - At edge N+1: done=1, div_by_zero=1, busy=0; hi/lo unchanged.
  - div_by_zero is cleared at the next op's start.
- Signed overflow, DIV most-negative / -1: lo = most-negative value, hi = 0, no flag.
- done is high for exactly one cycle.
  - start while done=1 is accepted; done falls on that edge.
- start while busy=1 is ignored; no queueing.
- hi_we/lo_we while busy=1 are ignored.
- hi_we/lo_we in the same IDLE cycle as start: the write takes effect, then is overwritten by the result at completion.
- hi_we and lo_we together write both registers.
- Operand inputs a/b/op are don't-care after the start edge.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF, start at edge 0 -> busy for 33 cycles; done at edge 33; hi=0xFFFFFFFE lo=0x00000001 div_by_zero=0.
- MULT a=0xFFFFFFFD(-3) b=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1; DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD(-3) hi=0xFFFFFFFF(-1); DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0.
- MTHI wd=0x12345678 and MTLO wd=0x9ABCDEF0, then DIVU a=100 b=0 -> done and div_by_zero at edge 1; hi=0x12345678 and lo=0x9ABCDEF0 retained.
- DIVU a=100 b=7 with start re-pulsed and hi_we=1 at cycle 10 -> both ignored; lo=14 hi=2 at edge 33; a new start in the done cycle is accepted and busy stays 1.
- reset asserted asynchronously at cycle 15 of a MULT -> busy/done/hi/lo=0 immediately; after release a fresh MULTU 6x7 gives lo=42 hi=0.
- WIDTH=8 instance: MULTU 0xFF x 0xFF -> hi=0xFE lo=0x01 with done after 9 busy cycles.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers.
// Operands are run as magnitudes; signs are reapplied in a single FIX cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic [WIDTH-1:0]  opnd_q, opnd_d;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0]  acc_hi_q, acc_hi_d; // product upper half / partial remainder
  logic [WIDTH-1:0]  acc_lo_q, acc_lo_d; // multiplier-product / dividend-quotient
  logic              nsign_q, nsign_d;
  logic              rsign_q, rsign_d;
  logic              zdiv_q, zdiv_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              dbz_q, dbz_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;

  logic              sgn_in;
  logic [WIDTH-1:0]  a_abs, b_abs;
  logic [WIDTH:0]    mul_sum;
  logic [WIDTH:0]    div_shl;
  logic              div_ge;
  logic [WIDTH-1:0]  div_rem;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]  res_hi, res_lo;

  assign sgn_in = ~op[0];
  assign a_abs  = (sgn_in & a[WIDTH-1]) ? -a : a;
  assign b_abs  = (sgn_in & b[WIDTH-1]) ? -b : b;

  // Shift-add step: add multiplicand when the multiplier LSB is set, then shift right.
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);

  // Restoring divide step; the remainder always stays below the divisor so
  // the subtracted result fits back into WIDTH bits.
  assign div_shl = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_ge  = div_shl >= {1'b0, opnd_q};
  assign div_rem = div_ge ? WIDTH'(div_shl - {1'b0, opnd_q}) : div_shl[WIDTH-1:0];

  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = nsign_q ? -prod : prod;
  assign res_hi   = is_div_q ? (rsign_q ? -acc_hi_q : acc_hi_q) : prod_fix[2*WIDTH-1:WIDTH];
  assign res_lo   = is_div_q ? (nsign_q ? -acc_lo_q : acc_lo_q) : prod_fix[WIDTH-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    opnd_d   = opnd_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    nsign_d  = nsign_q;
    rsign_d  = rsign_q;
    zdiv_d   = zdiv_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (hi_we) hi_d = wd;
        if (lo_we) lo_d = wd;
        if (start) begin
          is_div_d = op[1];
          opnd_d   = op[1] ? b_abs : a_abs;
          acc_hi_d = '0;
          acc_lo_d = op[1] ? a_abs : b_abs;
          nsign_d  = sgn_in & (a[WIDTH-1] ^ b[WIDTH-1]);
          rsign_d  = sgn_in & a[WIDTH-1];
          zdiv_d   = op[1] & (b == '0);
          cnt_d    = CW'(WIDTH);
          busy_d   = 1'b1;
          dbz_d    = 1'b0;
          state_d  = (op[1] && b == '0) ? FIX : RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (is_div_q) begin
          acc_hi_d = div_rem;
          acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
          acc_hi_d = mul_sum[WIDTH:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (zdiv_q) begin
          dbz_d = 1'b1;
        end else begin
          hi_d = res_hi;
          lo_d = res_lo;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      opnd_q   <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      nsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      zdiv_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      opnd_q   <= opnd_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      nsign_q  <= nsign_d;
      rsign_q  <= rsign_d;
      zdiv_q   <= zdiv_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: a 32-bit and an 8-bit instance.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        s32 = 0, hwe32 = 0, lwe32 = 0;
  logic [1:0]  op32 = 0;
  logic [31:0] a32 = 0, b32 = 0, wd32 = 0;
  logic        busy32, done32, dbz32;
  logic [31:0] hi32, lo32;

  logic        s8 = 0;
  logic [1:0]  op8 = 0;
  logic [7:0]  a8 = 0, b8 = 0;
  logic        busy8, done8, dbz8;
  logic [7:0]  hi8, lo8;

  muldiv_unit #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .start(s32), .op(op32), .a(a32), .b(b32),
    .hi_we(hwe32), .lo_we(lwe32), .wd(wd32), .busy(busy32), .done(done32),
    .div_by_zero(dbz32), .hi(hi32), .lo(lo32));

  muldiv_unit #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(s8), .op(op8), .a(a8), .b(b8),
    .hi_we(1'b0), .lo_we(1'b0), .wd(8'h00), .busy(busy8), .done(done8),
    .div_by_zero(dbz8), .hi(hi8), .lo(lo8));

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          cyc;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  exp_t e32, e8;
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    if (done32 === 1'b1) begin
      if (q32.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL d32_unexpected_done: got done=1 want no completion (t=%0t)", $time);
      end else begin
        e32 = q32.pop_front();
        chk("d32_hi", hi32, e32.hi);
        chk("d32_lo", lo32, e32.lo);
        chk("d32_dbz", {31'b0, dbz32}, {31'b0, e32.dbz});
        chk("d32_done_cycle", cyc, e32.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL d8_unexpected_done: got done=1 want no completion (t=%0t)", $time);
      end else begin
        e8 = q8.pop_front();
        chk("d8_hi", {24'b0, hi8}, e8.hi);
        chk("d8_lo", {24'b0, lo8}, e8.lo);
        chk("d8_dbz", {31'b0, dbz8}, {31'b0, e8.dbz});
        chk("d8_done_cycle", cyc, e8.cyc);
      end
    end
  end

  // Called at a negedge; drives start for exactly one edge.
  task automatic issue(input bit w8, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input logic ed, input bit push);
    exp_t e;
    e.hi = eh; e.lo = el; e.dbz = ed;
    if (w8) begin
      e.cyc = cyc + 1 + (ed ? 1 : 9);
      s8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
      if (push) q8.push_back(e);
    end else begin
      e.cyc = cyc + 1 + (ed ? 1 : 33);
      s32 = 1'b1; op32 = op; a32 = a; b32 = b;
      if (push) q32.push_back(e);
    end
    @(negedge clk);
    s8 = 1'b0; s32 = 1'b0;
  endtask

  task automatic wait_done(input bit w8);
    for (int i = 0; i < 60 && (w8 ? done8 : done32) !== 1'b1; i++) @(negedge clk);
    chk(w8 ? "wait_done8" : "wait_done32", {31'b0, (w8 ? done8 : done32)}, 32'd1);
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy32}, 32'd0);
    chk("rst_done", {31'b0, done32}, 32'd0);
    chk("rst_dbz", {31'b0, dbz32}, 32'd0);
    chk("rst_hi", hi32, 32'd0);
    chk("rst_lo", lo32, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // MULTU max x max
    issue(0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1);
    chk("multu_busy_start", {31'b0, busy32}, 32'd1);
    repeat (31) @(negedge clk);
    chk("multu_busy_late", {31'b0, busy32}, 32'd1);
    wait_done(0);
    chk("multu_busy_done", {31'b0, busy32}, 32'd0);
    @(negedge clk);

    issue(0, 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1);
    wait_done(0); @(negedge clk);
    issue(0, 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1);
    wait_done(0); @(negedge clk);
    issue(0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 1);
    wait_done(0); @(negedge clk);

    // MTHI / MTLO then divide by zero keeps them
    hwe32 = 1'b1; wd32 = 32'h1234_5678; @(negedge clk);
    hwe32 = 1'b0; lwe32 = 1'b1; wd32 = 32'h9ABC_DEF0; @(negedge clk);
    lwe32 = 1'b0;
    chk("mthi", hi32, 32'h1234_5678);
    chk("mtlo", lo32, 32'h9ABC_DEF0);
    issue(0, 2'b11, 32'd100, 32'd0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1);
    wait_done(0);
    chk("dbz_busy_done", {31'b0, busy32}, 32'd0);
    @(negedge clk);

    // DIVU with start and hi_we during busy (ignored), then restart in done cycle
    issue(0, 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1);
    repeat (8) @(negedge clk);
    s32 = 1'b1; op32 = 2'b01; a32 = 32'd5; b32 = 32'd5; hwe32 = 1'b1; wd32 = 32'hDEAD_BEEF;
    @(negedge clk);
    s32 = 1'b0; hwe32 = 1'b0;
    chk("busy_hi_we_ignored", hi32, 32'h1234_5678);
    chk("busy_mid_divu", {31'b0, busy32}, 32'd1);
    wait_done(0);
    issue(0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0, 1);
    chk("restart_busy", {31'b0, busy32}, 32'd1);
    chk("restart_done_fell", {31'b0, done32}, 32'd0);
    wait_done(0); @(negedge clk);

    // Asynchronous reset mid-MULT aborts without a completion
    issue(0, 2'b00, 32'd7, 32'd9, 32'd0, 32'd0, 1'b0, 0);
    repeat (13) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", {31'b0, busy32}, 32'd0);
    chk("arst_done", {31'b0, done32}, 32'd0);
    chk("arst_hi", hi32, 32'd0);
    chk("arst_lo", lo32, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // MTHI in the start cycle lands, then the result overwrites it
    hwe32 = 1'b1; wd32 = 32'h55;
    issue(0, 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1);
    hwe32 = 1'b0;
    chk("start_cycle_mthi", hi32, 32'h55);
    wait_done(0); @(negedge clk);

    // 8-bit instance
    issue(1, 2'b01, 32'hFF, 32'hFF, 32'hFE, 32'h01, 1'b0, 1);
    chk("w8_busy", {31'b0, busy8}, 32'd1);
    wait_done(1); @(negedge clk);
    issue(1, 2'b10, 32'h80, 32'hFF, 32'h00, 32'h80, 1'b0, 1);
    wait_done(1); @(negedge clk);
    issue(1, 2'b00, 32'h80, 32'h80, 32'h40, 32'h00, 1'b0, 1);
    wait_done(1);

    repeat (3) @(negedge clk);
    chk("q32_drained", q32.size(), 32'd0);
    chk("q8_drained", q8.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
